// File: rtl/zeta_fetch_ctrl.sv
// Zeta ROM read sequencer: walks k in NTT/INTT order and repeats each zeta len times on a valid/ready stream.
// Optional ZETA_NEG_EN: in INTT mode the captured zeta is replaced by Q - rom_do (0 stays 0).
module zeta_fetch_ctrl #(
  parameter int          WIDTH  = 23,
  parameter int          ADDR_W = 8,
  parameter int unsigned Q      = 8380417
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  output logic              busy,
  output logic              done,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [WIDTH-1:0]  rom_do,
  output logic              zeta_valid,
  input  logic              zeta_ready,
  output logic [WIDTH-1:0]  zeta,
  output logic [2:0]        zeta_layer,
  output logic              zeta_last
);

`ifdef ZETA_NEG_EN
  localparam bit NEG_EN = 1'b1;
`else
  localparam bit NEG_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, EMIT, DONE} state_t;

  state_t              state_q, state_d;
  logic                mode_q, mode_d;
  logic [ADDR_W-1:0]   k_q, k_d;
  logic [2:0]          lg_q, lg_d;
  logic [6:0]          b_q, b_d;
  logic [WIDTH-1:0]    zeta_q, zeta_d;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic                busy_q, busy_d, done_q, done_d, rom_en_q, rom_en_d;
  logic                valid_q, valid_d, last_q, last_d;
  logic [2:0]          layer_q, layer_d;
  logic                final_grp, final_grp_d;

  function automatic logic [6:0] len_m1(input logic [2:0] lg);
    return 7'((8'd1 << lg) - 8'd1);
  endfunction

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    k_d       = k_q;
    lg_d      = lg_q;
    b_d       = b_q;
    zeta_d    = zeta_q;
    final_grp = mode_q ? (k_q == ADDR_W'(1)) : (k_q == '1);
    case (state_q)
      IDLE: begin
        if (start) begin
          mode_d  = mode;
          k_d     = mode ? '1 : ADDR_W'(1);
          lg_d    = mode ? 3'd0 : 3'd7;
          b_d     = '0;
          state_d = FETCH;
        end
      end
      FETCH: state_d = WAIT;
      WAIT: begin
        if (NEG_EN && mode_q && (rom_do != '0)) zeta_d = WIDTH'(Q) - rom_do;
        else                                    zeta_d = rom_do;
        state_d = EMIT;
      end
      EMIT: begin
        if (zeta_ready) begin
          if (b_q != len_m1(lg_q)) begin
            b_d = b_q + 7'd1;
          end else begin
            b_d = '0;
            if (final_grp) begin
              state_d = DONE;
            end else if (!mode_q) begin
              // layer shrinks when the next k starts a new power-of-two block
              k_d = k_q + ADDR_W'(1);
              if (((k_q + ADDR_W'(1)) & k_q) == '0) lg_d = lg_q - 3'd1;
              state_d = FETCH;
            end else begin
              k_d = k_q - ADDR_W'(1);
              if ((k_q & (k_q - ADDR_W'(1))) == '0) lg_d = lg_q + 3'd1;
              state_d = FETCH;
            end
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // outputs are registered: decode them from the next-state values
    final_grp_d = mode_d ? (k_d == ADDR_W'(1)) : (k_d == '1);
    busy_d      = (state_d == FETCH) || (state_d == WAIT) || (state_d == EMIT);
    done_d      = (state_d == DONE);
    rom_en_d    = (state_d == FETCH);
    rom_addr_d  = (state_d == FETCH) ? k_d : rom_addr_q;
    valid_d     = (state_d == EMIT);
    layer_d     = lg_d;
    last_d      = (state_d == EMIT) && final_grp_d && (b_d == len_m1(lg_d));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      mode_q     <= 1'b0;
      k_q        <= '0;
      lg_q       <= '0;
      b_q        <= '0;
      zeta_q     <= '0;
      rom_addr_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rom_en_q   <= 1'b0;
      valid_q    <= 1'b0;
      layer_q    <= '0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      k_q        <= k_d;
      lg_q       <= lg_d;
      b_q        <= b_d;
      zeta_q     <= zeta_d;
      rom_addr_q <= rom_addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rom_en_q   <= rom_en_d;
      valid_q    <= valid_d;
      layer_q    <= layer_d;
      last_q     <= last_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign rom_en     = rom_en_q;
  assign rom_addr   = rom_addr_q;
  assign zeta_valid = valid_q;
  assign zeta       = zeta_q;
  assign zeta_layer = layer_q;
  assign zeta_last  = last_q;

endmodule

// File: tb/tb_zeta_fetch_ctrl.sv
// Bench for zeta_fetch_ctrl: ROM model, beat-order reference built from layer/group loops, random ready.
module tb_zeta_fetch_ctrl;

`ifdef ZETA_NEG_EN
  localparam bit NEG = 1'b1;
`else
  localparam bit NEG = 1'b0;
`endif
  localparam int QTB = 8380417;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic        busy, done, rom_en, zeta_valid, zeta_last;
  logic [7:0]  rom_addr;
  logic [22:0] rom_do = '0;
  logic        zeta_ready = 1'b0;
  logic [22:0] zeta;
  logic [2:0]  zeta_layer;

  logic [22:0] rom_mem [256];
  int          exp_k [1024];
  int          exp_l [1024];
  int          vectors = 0;
  int          miscompares = 0;

  zeta_fetch_ctrl #(.WIDTH(23), .ADDR_W(8), .Q(8380417)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .busy(busy), .done(done),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_do(rom_do), .zeta_valid(zeta_valid),
    .zeta_ready(zeta_ready), .zeta(zeta), .zeta_layer(zeta_layer), .zeta_last(zeta_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rom_en) rom_do <= rom_mem[rom_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic logic [22:0] ez(input int k, input bit md);
    logic [22:0] r;
    r = rom_mem[k];
    if (NEG && md && r != 0) return 23'(QTB - int'(r));
    return r;
  endfunction

  task automatic build(input bit md);
    int idx;
    idx = 0;
    for (int s = 0; s < 8; s++) begin
      int lg;
      lg = md ? s : 7 - s;
      for (int j = 0; j < (1 << (7 - lg)); j++) begin
        int k;
        k = md ? ((2 << (7 - lg)) - 1 - j) : ((1 << (7 - lg)) + j);
        for (int r = 0; r < (1 << lg); r++) begin
          exp_k[idx] = k;
          exp_l[idx] = lg;
          idx++;
        end
      end
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rom_en"}, rom_en, 0);
    chk({tag, "_rom_addr"}, rom_addr, 0);
    chk({tag, "_valid"}, zeta_valid, 0);
    chk({tag, "_zeta"}, zeta, 0);
    chk({tag, "_layer"}, zeta_layer, 0);
    chk({tag, "_last"}, zeta_last, 0);
  endtask

  task automatic run(input bit md, input int ready_pct, input int abort_at, input bit hold_start);
    int beat, cyc, busy_cyc, valid_cyc, roms;
    bit stalled, done_seen;
    logic [22:0] hz;
    logic [2:0]  hl;
    logic        hlast;
    build(md);
    beat = 0; cyc = 0; busy_cyc = -1; valid_cyc = -1; roms = 0;
    stalled = 0; done_seen = 0; hz = '0; hl = '0; hlast = 0;
    mode = md; start = 1'b1; zeta_ready = 1'b0;
    while (!done_seen && cyc < 6000) begin
      @(posedge clk); #1; cyc++;
      if (!hold_start) start = 1'b0;
      else if (beat >= 500) mode = ~md;
      if (busy && busy_cyc < 0) busy_cyc = cyc;
      if (zeta_valid && valid_cyc < 0) begin
        valid_cyc = cyc;
        chk("first_valid_latency", valid_cyc - busy_cyc, 2);
      end
      if (rom_en) begin
        roms++;
        chk("rom_addr_order", rom_addr, exp_k[beat]);
        chk("rom_en_vs_valid", zeta_valid, 0);
      end
      if (stalled) begin
        chk("stall_valid", zeta_valid, 1);
        chk("stall_zeta", zeta, hz);
        chk("stall_layer", zeta_layer, hl);
        chk("stall_last", zeta_last, hlast);
      end
      if (beat == 1024) begin
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 0);
        chk("done_valid", zeta_valid, 0);
        done_seen = 1;
      end else begin
        chk("no_early_done", done, 0);
        if (zeta_valid) begin
          chk("beat_zeta", zeta, ez(exp_k[beat], md));
          chk("beat_layer", zeta_layer, exp_l[beat]);
          chk("beat_last", zeta_last, (beat == 1023) ? 1 : 0);
        end
        if (abort_at >= 0 && beat == abort_at) begin
          #2 rst = 1'b1;
          #1 check_reset_vals("async_reset");
          @(posedge clk); #1 rst = 1'b0;
          for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("post_reset_done", done, 0);
            chk("post_reset_busy", busy, 0);
          end
          return;
        end
        zeta_ready = ($urandom_range(99) < ready_pct);
        stalled = zeta_valid && !zeta_ready;
        hz = zeta; hl = zeta_layer; hlast = zeta_last;
        if (zeta_valid && zeta_ready) beat++;
      end
    end
    chk("done_seen", done_seen, 1);
    chk("rom_reads", roms, 255);
    @(posedge clk); #1;
    chk("done_single", done, 0);
    chk("idle_busy", busy, 0);
    if (hold_start) begin
      @(posedge clk); #1;
      chk("restart_busy", busy, 1);
      chk("restart_rom_en", rom_en, 1);
      chk("restart_addr", rom_addr, md ? 1 : 255);
      start = 1'b0;
      #2 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      check_reset_vals("restart_reset");
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom_mem[i] = 23'(i);
    rst = 1'b1;
    #12;
    check_reset_vals("reset");
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    check_reset_vals("idle");

    run(1'b0, 100, -1, 1'b0);
    run(1'b1, 100, -1, 1'b0);
    for (int i = 0; i < 256; i++) rom_mem[i] = 23'($urandom_range(QTB - 1));
    run(1'b0, 50, -1, 1'b0);
    run(1'b1, 50, -1, 1'b0);
    for (int i = 0; i < 256; i++) rom_mem[i] = 23'(i);
    run(1'b0, 50, 300, 1'b0);
    run(1'b0, 100, -1, 1'b0);
    run(1'b0, 70, -1, 1'b1);
    for (int i = 0; i < 256; i++) rom_mem[i] = 23'($urandom_range(QTB - 1));
    rom_mem[255] = 23'd25847;
    rom_mem[1]   = 23'd0;
    run(1'b1, 60, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
